// File: rtl/vector_write_engine.sv
// vector_write_engine
//   Collects a vector of DATA_WIDTH-bit elements from a UART byte stream
//   (low byte first) and writes it into memory A or B, one element per
//   COMMIT cycle, followed by a short flush and a write_done pulse.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for a begin_write rising edge
//   LOW    | waiting for the low byte of the current element
//   HIGH   | waiting for the high byte of the current element
//   COMMIT | one-cycle write of the assembled element to the sel_q memory
//   FLUSH  | two cycles with the enable held high and no write
//   DONE   | one-cycle write_done pulse
//
// Ports
//   clk, reset_n         system clock, asynchronous active-low reset
//   begin_write          level request, held high for the whole operation
//   mem_sel              target memory (0 = A, 1 = B), latched at start
//   rx_ready, rx_data    one-cycle valid strobe and received byte
//   ena/enb, wea/web     memory A/B enables and write enables
//   waddr, wdata         write address (element counter) and data
//   write_done           one-cycle pulse after the full vector is written
//   busy                 high whenever the engine is not in IDLE
//
// The address path is 10 bits wide, so NUM_ELEMENTOS must not exceed 1024.
module vector_write_engine #(
  parameter int NUM_ELEMENTOS = 1024,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  begin_write,
  input  logic                  mem_sel,
  input  logic                  rx_ready,
  input  logic [7:0]            rx_data,
  output logic                  ena,
  output logic                  enb,
  output logic                  wea,
  output logic                  web,
  output logic [9:0]            waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  write_done,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOW, S_HIGH, S_COMMIT, S_FLUSH, S_DONE
  } state_t;

  localparam logic [9:0] LAST = 10'(NUM_ELEMENTOS - 1);

  state_t                state_q, state_d;
  logic                  bw_prev_q;
  logic                  sel_q, sel_d;
  logic [9:0]            cnt_q, cnt_d;
  logic [7:0]            low_q, low_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  flush_q, flush_d;

  logic                  ena_q, enb_q, wea_q, web_q, done_q, busy_q;
  logic [9:0]            waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic bw_rise;
  logic en_d, wr_d;

  assign bw_rise = begin_write & ~bw_prev_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    low_d   = low_q;
    word_d  = word_q;
    flush_d = flush_q;

    case (state_q)
      S_IDLE: begin
        if (bw_rise) begin
          sel_d   = mem_sel;
          cnt_d   = '0;
          low_d   = '0;
          word_d  = '0;
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (!begin_write) begin
          state_d = S_IDLE;
        end else if (rx_ready) begin
          low_d   = rx_data;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (!begin_write) begin
          state_d = S_IDLE;
        end else if (rx_ready) begin
          word_d  = DATA_WIDTH'({rx_data, low_q});
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        if (!begin_write) begin
          state_d = S_IDLE;
        end else if (cnt_q == LAST) begin
          flush_d = 1'b0;
          state_d = S_FLUSH;
        end else begin
          cnt_d = cnt_q + 10'd1;
          // A byte landing during COMMIT is already the next low byte.
          if (rx_ready) begin
            low_d   = rx_data;
            state_d = S_HIGH;
          end else begin
            state_d = S_LOW;
          end
        end
      end
      S_FLUSH: begin
        if (flush_q) state_d = S_DONE;
        else         flush_d = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the next state.
    wr_d = (state_d == S_COMMIT);
    en_d = (state_d == S_COMMIT) || (state_d == S_FLUSH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      bw_prev_q <= 1'b0;
      sel_q     <= 1'b0;
      cnt_q     <= '0;
      low_q     <= '0;
      word_q    <= '0;
      flush_q   <= 1'b0;
      ena_q     <= 1'b0;
      enb_q     <= 1'b0;
      wea_q     <= 1'b0;
      web_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      bw_prev_q <= begin_write;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      low_q     <= low_d;
      word_q    <= word_d;
      flush_q   <= flush_d;
      ena_q     <= en_d & ~sel_d;
      enb_q     <= en_d &  sel_d;
      wea_q     <= wr_d & ~sel_d;
      web_q     <= wr_d &  sel_d;
      done_q    <= (state_d == S_DONE);
      busy_q    <= (state_d != S_IDLE);
      waddr_q   <= cnt_d;
      wdata_q   <= word_d;
    end
  end

  assign ena        = ena_q;
  assign enb        = enb_q;
  assign wea        = wea_q;
  assign web        = web_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign write_done = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_vector_write_engine.sv
// tb_vector_write_engine
//   Randomized-stimulus bench for vector_write_engine. A byte-level model
//   pairs bytes into words and predicts every write (memory, address, data,
//   cycle) plus the write_done timing; a negedge monitor records what the
//   DUT actually does.
module tb_vector_write_engine;

  localparam int N  = 1024;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          begin_write, mem_sel, rx_ready;
  logic [7:0]    rx_data;
  logic          ena, enb, wea, web, write_done, busy;
  logic [9:0]    waddr;
  logic [DW-1:0] wdata;

  vector_write_engine #(.NUM_ELEMENTOS(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .begin_write(begin_write),
    .mem_sel(mem_sel), .rx_ready(rx_ready), .rx_data(rx_data),
    .ena(ena), .enb(enb), .wea(wea), .web(web), .waddr(waddr),
    .wdata(wdata), .write_done(write_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int mem;
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t obs_q[$];
  wr_t exp_q[$];
  wr_t mon_rec;

  int checks = 0;
  int errors = 0;
  int done_n, done_cyc, ena_n, enb_n, flush_n;
  int viol_n = 0;

  // model state
  int       sel_m, elem_m;
  bit       phase_m, active_m;
  bit [7:0] low_m;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wea || web) begin
      mon_rec.mem  = web ? 1 : 0;
      mon_rec.addr = int'(waddr);
      mon_rec.data = int'(wdata);
      mon_rec.cyc  = cyc;
      obs_q.push_back(mon_rec);
    end
    if (write_done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (ena) ena_n++;
    if (enb) enb_n++;
    if ((ena || enb) && !wea && !web) flush_n++;
    if ((wea && web) || (ena && enb) || (wea && !ena) || (web && !enb))
      viol_n++;
  end

  task automatic clear_obs();
    obs_q.delete();
    done_n  = 0;
    ena_n   = 0;
    enb_n   = 0;
    flush_n = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a posedge with begin_write low.
  task automatic start_op(input int sel);
    mem_sel     = sel[0];
    begin_write = 1'b1;
    tick(1);
    sel_m    = sel;
    elem_m   = 0;
    phase_m  = 0;
    active_m = 1;
    exp_q.delete();
    clear_obs();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int e;
    tick(gap);
    rx_data  = b;
    rx_ready = 1'b1;
    e = cyc + 1;
    tick(1);
    rx_ready = 1'b0;
    if (active_m) begin
      if (!phase_m) begin
        low_m   = b;
        phase_m = 1;
      end else begin
        if (elem_m < N) exp_q.push_back('{sel_m, elem_m, int'({b, low_m}), e});
        elem_m++;
        phase_m = 0;
      end
    end
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_nwrites"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_mem"},  obs_q[i].mem,  exp_q[i].mem);
      check({tag, "_addr"}, obs_q[i].addr, exp_q[i].addr);
      check({tag, "_data"}, obs_q[i].data, exp_q[i].data);
      check({tag, "_cyc"},  obs_q[i].cyc,  exp_q[i].cyc);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ena"},  int'(ena), 0);
    check({tag, "_enb"},  int'(enb), 0);
    check({tag, "_wea"},  int'(wea), 0);
    check({tag, "_web"},  int'(web), 0);
    check({tag, "_waddr"}, int'(waddr), 0);
    check({tag, "_wdata"}, int'(wdata), 0);
    check({tag, "_done"}, int'(write_done), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic check_full_run(input string tag, input int sel);
    compare_writes(tag);
    check({tag, "_done_n"}, done_n, 1);
    if (exp_q.size() > 0)
      check({tag, "_done_cyc"}, done_cyc, exp_q[exp_q.size()-1].cyc + 3);
    check({tag, "_flush_cycles"}, flush_n, 2);
    check({tag, "_other_en"}, sel ? ena_n : enb_n, 0);
    check({tag, "_busy_end"}, int'(busy), 0);
  endtask

  initial begin
    int w, g, sel;
    reset_n     = 1'b0;
    begin_write = 1'b0;
    mem_sel     = 1'b0;
    rx_ready    = 1'b0;
    rx_data     = 8'h00;
    active_m    = 0;
    tick(3);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    tick(2);

    // Full write to A, element i = i+1, random gaps including back-to-back
    start_op(0);
    for (int i = 0; i < N; i++) begin
      w = i + 1;
      send_byte(w[7:0],  $urandom_range(0, 2));
      send_byte(w[15:8], $urandom_range(0, 2));
    end
    active_m = 0;
    tick(8);
    check_full_run("full_a", 0);

    // begin_write still high: no restart, bytes ignored
    clear_obs();
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
    tick(6);
    check("hold_nwrites", obs_q.size(), 0);
    check("hold_done_n", done_n, 0);
    check("hold_busy", int'(busy), 0);
    begin_write = 1'b0;
    tick(2);

    // Full write to B, all bytes 0xFF
    start_op(1);
    for (int i = 0; i < 2 * N; i++) send_byte(8'hFF, $urandom_range(0, 1));
    active_m = 0;
    tick(8);
    check_full_run("full_b", 1);
    begin_write = 1'b0;
    tick(2);

    // Abort after 5 elements + 1 byte, bytes back-to-back with random data
    sel = int'($urandom_range(0, 1));
    start_op(sel);
    for (int i = 0; i < 11; i++) send_byte(8'($urandom), 0);
    begin_write = 1'b0;
    active_m    = 0;
    tick(1);
    check("abort_busy", int'(busy), 0);
    tick(6);
    compare_writes("abort");
    check("abort_done_n", done_n, 0);
    check("abort_busy_late", int'(busy), 0);
    tick(2);

    // Reset in the middle of element 300
    sel = int'($urandom_range(0, 1));
    start_op(sel);
    for (int i = 0; i < 601; i++) begin
      g = int'($urandom_range(0, 2));
      send_byte(8'($urandom), g);
    end
    active_m = 0;
    #2;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    compare_writes("pre_rst");
    begin_write = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(2);
    check("postrst_done_n", done_n, 0);

    // Restart after reset begins again at address 0
    start_op(1 - sel);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), $urandom_range(0, 1));
    tick(3);
    compare_writes("restart");
    begin_write = 1'b0;
    active_m    = 0;
    tick(4);
    check("restart_busy", int'(busy), 0);

    check("protocol_violations", viol_n, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
